// File: rtl/maccum_arbiter_pkg.sv
// maccum_arbiter_pkg: shared defaults and derived widths for the Maccum arbiter
package maccum_arbiter_pkg;
  localparam int DEF_NP = 7;
  localparam int DEF_NC = 11;
  localparam int DEF_WF = 5;
  localparam int DEF_DEPTH = 4;
  localparam int ACC_W = $clog2(DEF_NP) + DEF_WF;
  localparam int STATE_W = DEF_NP * DEF_WF;
  localparam int TAG_W = 1;
  localparam int CNT_W = $clog2(DEF_DEPTH + 1);
endpackage

// File: rtl/maccum_arbiter_tag_fifo.sv
// maccum_arbiter_tag_fifo: in-order requester-ID FIFO for beats in flight through Maccum
module maccum_arbiter_tag_fifo import maccum_arbiter_pkg::*; #(
  parameter int DEPTH = DEF_DEPTH,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             i_push,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_pop,
  output logic [TAG_W-1:0] o_head,
  output logic [CW-1:0]    o_count
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [TAG_W-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic w_push, w_pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign w_push = i_push && (r_cnt != CW'(DEPTH));
  assign w_pop = i_pop && (r_cnt != '0);
  assign o_head = r_mem[r_rp];
  assign o_count = r_cnt;
  // circular pointers; a full FIFO refuses push even when popping the same cycle
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_tag;
        r_wp <= nxt(r_wp);
      end
      if (w_pop) r_rp <= nxt(r_rp);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/maccum_arbiter.sv
// maccum_arbiter: round-robin sharing of one Maccum between two requesters with in-order result routing
module maccum_arbiter import maccum_arbiter_pkg::*; #(
  parameter int NP = DEF_NP,
  parameter int NC = DEF_NC,
  parameter int WF = DEF_WF,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                         iCLK,
  input  logic                         iRST,
  input  logic                         iValid_AM_State0,
  output logic                         oReady_AM_State0,
  input  logic [NP*WF-1:0]             iData_AM_State0,
  input  logic                         iValid_AM_State1,
  output logic                         oReady_AM_State1,
  input  logic [NP*WF-1:0]             iData_AM_State1,
  output logic                         oValid_BM_State,
  input  logic                         iReady_BM_State,
  output logic [NP*WF-1:0]             oData_BM_State,
  input  logic                         iValid_AM_Accum,
  output logic                         oReady_AM_Accum,
  input  logic [NC*($clog2(NP)+WF)-1:0] iData_AM_Accum,
  output logic                         oValid_BM_Accum0,
  input  logic                         iReady_BM_Accum0,
  output logic [NC*($clog2(NP)+WF)-1:0] oData_BM_Accum0,
  output logic                         oValid_BM_Accum1,
  input  logic                         iReady_BM_Accum1,
  output logic [NC*($clog2(NP)+WF)-1:0] oData_BM_Accum1,
  output logic                         oErr
);
  localparam int CW = $clog2(DEPTH + 1);
  logic r_valid, r_ptr, r_err;
  logic [NP*WF-1:0] r_data;
  logic w_grant, w_can_issue, w_accept, w_head, w_nonempty, w_pop;
  logic [CW-1:0] w_count;
  // count covers the issue register too, so credit is taken at accept time
  always_comb begin
    w_can_issue = !iRST && (!r_valid || iReady_BM_State) && (w_count < CW'(DEPTH));
    w_grant = (iValid_AM_State0 && iValid_AM_State1) ? !r_ptr : iValid_AM_State1;
    oReady_AM_State0 = w_can_issue && !w_grant;
    oReady_AM_State1 = w_can_issue && w_grant;
    w_accept = (oReady_AM_State0 && iValid_AM_State0) || (oReady_AM_State1 && iValid_AM_State1);
  end
  // one-entry issue register; pointer remembers the last winner
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_valid <= 1'b0;
      r_data <= '0;
      r_ptr <= 1'b1;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_data <= w_grant ? iData_AM_State1 : iData_AM_State0;
      r_ptr <= w_grant;
    end else if (iReady_BM_State) begin
      r_valid <= 1'b0;
    end
  end
  assign oValid_BM_State = r_valid;
  assign oData_BM_State = r_data;
  maccum_arbiter_tag_fifo #(.DEPTH(DEPTH), .CW(CW)) u_tag_fifo (
    .iCLK(iCLK),
    .iRST(iRST),
    .i_push(w_accept),
    .i_tag(w_grant),
    .i_pop(w_pop),
    .o_head(w_head),
    .o_count(w_count)
  );
  // results follow the head tag; a stalled head consumer blocks the other
  always_comb begin
    w_nonempty = w_count != '0;
    oValid_BM_Accum0 = iValid_AM_Accum && w_nonempty && !w_head;
    oValid_BM_Accum1 = iValid_AM_Accum && w_nonempty && w_head;
    oReady_AM_Accum = w_nonempty && (w_head ? iReady_BM_Accum1 : iReady_BM_Accum0);
    w_pop = iValid_AM_Accum && oReady_AM_Accum;
  end
  assign oData_BM_Accum0 = iData_AM_Accum;
  assign oData_BM_Accum1 = iData_AM_Accum;
  // a result with nothing in flight is a protocol error, held until reset
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) r_err <= 1'b0;
    else if (iValid_AM_Accum && !w_nonempty) r_err <= 1'b1;
  end
  assign oErr = r_err;
endmodule

// File: tb/tb_maccum_arbiter.sv
// tb_maccum_arbiter: directed table-driven check of the Maccum arbiter
module tb_maccum_arbiter;
  import maccum_arbiter_pkg::*;
  localparam int AW = DEF_NC * ACC_W;
  logic iCLK = 1'b0, iRST = 1'b1;
  logic iValid_AM_State0, oReady_AM_State0, iValid_AM_State1, oReady_AM_State1;
  logic [STATE_W-1:0] iData_AM_State0, iData_AM_State1, oData_BM_State;
  logic oValid_BM_State, iReady_BM_State, iValid_AM_Accum, oReady_AM_Accum;
  logic [AW-1:0] iData_AM_Accum, oData_BM_Accum0, oData_BM_Accum1;
  logic oValid_BM_Accum0, iReady_BM_Accum0, oValid_BM_Accum1, iReady_BM_Accum1, oErr;
  int n_chk = 0, n_fail = 0;

  always #5 iCLK = ~iCLK;

  maccum_arbiter dut (
    .iCLK(iCLK), .iRST(iRST),
    .iValid_AM_State0(iValid_AM_State0), .oReady_AM_State0(oReady_AM_State0), .iData_AM_State0(iData_AM_State0),
    .iValid_AM_State1(iValid_AM_State1), .oReady_AM_State1(oReady_AM_State1), .iData_AM_State1(iData_AM_State1),
    .oValid_BM_State(oValid_BM_State), .iReady_BM_State(iReady_BM_State), .oData_BM_State(oData_BM_State),
    .iValid_AM_Accum(iValid_AM_Accum), .oReady_AM_Accum(oReady_AM_Accum), .iData_AM_Accum(iData_AM_Accum),
    .oValid_BM_Accum0(oValid_BM_Accum0), .iReady_BM_Accum0(iReady_BM_Accum0), .oData_BM_Accum0(oData_BM_Accum0),
    .oValid_BM_Accum1(oValid_BM_Accum1), .iReady_BM_Accum1(iReady_BM_Accum1), .oData_BM_Accum1(oData_BM_Accum1),
    .oErr(oErr)
  );

  typedef struct {
    logic v0; logic [7:0] d0; logic v1; logic [7:0] d1; logic rs;
    logic va; logic [7:0] da; logic ra0; logic ra1;
    logic e_r0; logic e_r1; logic e_vs; logic [7:0] e_ds; logic e_ra; logic e_va0; logic e_va1;
  } vec_t;
  vec_t tbl [15];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1,
                       input logic rs, input logic va, input logic [7:0] da, input logic ra0, input logic ra1);
    iValid_AM_State0 = v0; iData_AM_State0 = STATE_W'(d0);
    iValid_AM_State1 = v1; iData_AM_State1 = STATE_W'(d1);
    iReady_BM_State = rs;
    iValid_AM_Accum = va; iData_AM_Accum = AW'(da);
    iReady_BM_Accum0 = ra0; iReady_BM_Accum1 = ra1;
  endtask

  task automatic next_cycle();
    @(posedge iCLK);
    #1;
  endtask

  initial begin
    int acc;
    //            v0 d0     v1 d1     rs va da     ra0 ra1  r0 r1 vs ds     ra va0 va1
    tbl[0]  = '{1, 8'h01, 0, 8'h00, 1, 0, 8'h00, 0, 0,   1, 0, 0, 8'h00, 0, 0, 0};
    tbl[1]  = '{1, 8'h02, 0, 8'h00, 1, 0, 8'h00, 0, 0,   1, 0, 1, 8'h01, 0, 0, 0};
    tbl[2]  = '{1, 8'h03, 0, 8'h00, 1, 0, 8'h00, 0, 0,   1, 0, 1, 8'h02, 0, 0, 0};
    tbl[3]  = '{0, 8'h00, 0, 8'h00, 1, 1, 8'hA1, 1, 1,   1, 0, 1, 8'h03, 1, 1, 0};
    tbl[4]  = '{0, 8'h00, 0, 8'h00, 1, 1, 8'hA2, 1, 1,   1, 0, 0, 8'h00, 1, 1, 0};
    tbl[5]  = '{0, 8'h00, 0, 8'h00, 1, 1, 8'hA3, 1, 1,   1, 0, 0, 8'h00, 1, 1, 0};
    tbl[6]  = '{1, 8'h10, 1, 8'h20, 1, 0, 8'h00, 0, 0,   0, 1, 0, 8'h00, 0, 0, 0};
    tbl[7]  = '{1, 8'h10, 1, 8'h21, 1, 0, 8'h00, 0, 0,   1, 0, 1, 8'h20, 0, 0, 0};
    tbl[8]  = '{0, 8'h00, 1, 8'h21, 1, 0, 8'h00, 0, 0,   0, 1, 1, 8'h10, 0, 0, 0};
    tbl[9]  = '{0, 8'h00, 0, 8'h00, 1, 1, 8'hB1, 0, 1,   1, 0, 1, 8'h21, 1, 0, 1};
    tbl[10] = '{0, 8'h00, 0, 8'h00, 1, 1, 8'hB2, 0, 1,   1, 0, 0, 8'h00, 0, 1, 0};
    tbl[11] = '{0, 8'h00, 0, 8'h00, 1, 1, 8'hB2, 0, 1,   1, 0, 0, 8'h00, 0, 1, 0};
    tbl[12] = '{0, 8'h00, 0, 8'h00, 1, 1, 8'hB2, 1, 1,   1, 0, 0, 8'h00, 1, 1, 0};
    tbl[13] = '{0, 8'h00, 0, 8'h00, 1, 1, 8'hB3, 0, 1,   1, 0, 0, 8'h00, 1, 0, 1};
    tbl[14] = '{0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0, 0,   1, 0, 0, 8'h00, 0, 0, 0};

    drive(1, 8'h01, 1, 8'h02, 1, 1, 8'h00, 1, 1);
    #12;
    chk("reset ready0", 128'(oReady_AM_State0), 128'(0));
    chk("reset ready1", 128'(oReady_AM_State1), 128'(0));
    chk("reset valid_state", 128'(oValid_BM_State), 128'(0));
    chk("reset accum0", 128'(oValid_BM_Accum0), 128'(0));
    chk("reset accum1", 128'(oValid_BM_Accum1), 128'(0));
    chk("reset ready_accum", 128'(oReady_AM_Accum), 128'(0));
    chk("reset err", 128'(oErr), 128'(0));
    next_cycle();
    iRST = 1'b0;

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1, tbl[i].rs, tbl[i].va, tbl[i].da, tbl[i].ra0, tbl[i].ra1);
      @(negedge iCLK);
      chk($sformatf("row%0d ready0", i), 128'(oReady_AM_State0), 128'(tbl[i].e_r0));
      chk($sformatf("row%0d ready1", i), 128'(oReady_AM_State1), 128'(tbl[i].e_r1));
      chk($sformatf("row%0d valid_state", i), 128'(oValid_BM_State), 128'(tbl[i].e_vs));
      if (tbl[i].e_vs) chk($sformatf("row%0d data_state", i), 128'(oData_BM_State), 128'(tbl[i].e_ds));
      chk($sformatf("row%0d ready_accum", i), 128'(oReady_AM_Accum), 128'(tbl[i].e_ra));
      chk($sformatf("row%0d valid_accum0", i), 128'(oValid_BM_Accum0), 128'(tbl[i].e_va0));
      chk($sformatf("row%0d valid_accum1", i), 128'(oValid_BM_Accum1), 128'(tbl[i].e_va1));
      if (tbl[i].va) begin
        chk($sformatf("row%0d data_accum0", i), 128'(oData_BM_Accum0), 128'(tbl[i].da));
        chk($sformatf("row%0d data_accum1", i), 128'(oData_BM_Accum1), 128'(tbl[i].da));
      end
      chk($sformatf("row%0d err", i), 128'(oErr), 128'(0));
      next_cycle();
    end

    acc = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1, 8'h30, 0, 8'h00, 1, 0, 8'h00, 0, 0);
      @(negedge iCLK);
      if (oReady_AM_State0) acc++;
      next_cycle();
    end
    chk("credit accepts", 128'(acc), 128'(4));
    drive(1, 8'h30, 1, 8'h31, 1, 0, 8'h00, 0, 0);
    @(negedge iCLK);
    chk("credit full ready0", 128'(oReady_AM_State0), 128'(0));
    chk("credit full ready1", 128'(oReady_AM_State1), 128'(0));
    next_cycle();
    drive(1, 8'h30, 1, 8'h31, 1, 1, 8'hC1, 1, 0);
    @(negedge iCLK);
    chk("credit pop ready_accum", 128'(oReady_AM_Accum), 128'(1));
    chk("credit no bypass ready0", 128'(oReady_AM_State0), 128'(0));
    chk("credit no bypass ready1", 128'(oReady_AM_State1), 128'(0));
    next_cycle();
    drive(0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0, 0);
    @(negedge iCLK);
    chk("credit reenabled", 128'(oReady_AM_State0), 128'(1));
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      drive(0, 8'h00, 0, 8'h00, 1, 1, 8'hC2, 1, 0);
      @(negedge iCLK);
      chk($sformatf("credit drain%0d accum0", i), 128'(oValid_BM_Accum0), 128'(1));
      next_cycle();
    end

    drive(1, 8'h55, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    @(negedge iCLK);
    chk("bp first ready0", 128'(oReady_AM_State0), 128'(1));
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      drive(1, 8'h66, 0, 8'h00, 0, 0, 8'h00, 0, 0);
      @(negedge iCLK);
      chk($sformatf("bp%0d ready0", i), 128'(oReady_AM_State0), 128'(0));
      chk($sformatf("bp%0d valid_state", i), 128'(oValid_BM_State), 128'(1));
      chk($sformatf("bp%0d data_state", i), 128'(oData_BM_State), 128'(8'h55));
      next_cycle();
    end
    drive(1, 8'h66, 0, 8'h00, 1, 0, 8'h00, 0, 0);
    @(negedge iCLK);
    chk("bp drain ready0", 128'(oReady_AM_State0), 128'(1));
    chk("bp drain data", 128'(oData_BM_State), 128'(8'h55));
    next_cycle();
    drive(0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    @(negedge iCLK);
    chk("bp next valid", 128'(oValid_BM_State), 128'(1));
    chk("bp next data", 128'(oData_BM_State), 128'(8'h66));
    next_cycle();
    drive(0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0, 0);
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      drive(0, 8'h00, 0, 8'h00, 1, 1, 8'hD1, 1, 0);
      @(negedge iCLK);
      chk($sformatf("bp return%0d accum0", i), 128'(oValid_BM_Accum0), 128'(1));
      next_cycle();
    end

    drive(0, 8'h00, 0, 8'h00, 1, 1, 8'hE1, 1, 1);
    @(negedge iCLK);
    chk("err empty ready_accum", 128'(oReady_AM_Accum), 128'(0));
    chk("err empty accum0", 128'(oValid_BM_Accum0), 128'(0));
    chk("err before edge", 128'(oErr), 128'(0));
    next_cycle();
    drive(0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0, 0);
    @(negedge iCLK);
    chk("err set", 128'(oErr), 128'(1));
    repeat (3) next_cycle();
    chk("err sticky", 128'(oErr), 128'(1));
    drive(1, 8'h77, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    next_cycle();
    drive(1, 8'h77, 0, 8'h00, 0, 1, 8'hF1, 0, 0);
    @(negedge iCLK);
    chk("pre-reset valid_state", 128'(oValid_BM_State), 128'(1));
    chk("pre-reset accum0", 128'(oValid_BM_Accum0), 128'(1));
    #2 iRST = 1'b1;
    #1;
    chk("async reset err", 128'(oErr), 128'(0));
    chk("async reset valid_state", 128'(oValid_BM_State), 128'(0));
    chk("async reset ready0", 128'(oReady_AM_State0), 128'(0));
    chk("async reset accum0", 128'(oValid_BM_Accum0), 128'(0));
    chk("async reset ready_accum", 128'(oReady_AM_Accum), 128'(0));
    next_cycle();
    iRST = 1'b0;
    drive(0, 8'h00, 0, 8'h00, 1, 1, 8'hF2, 1, 1);
    @(negedge iCLK);
    chk("post-reset tags dropped", 128'(oValid_BM_Accum0), 128'(0));
    chk("post-reset ready_accum", 128'(oReady_AM_Accum), 128'(0));
    chk("post-reset valid_state", 128'(oValid_BM_State), 128'(0));
    next_cycle();
    drive(0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
